// File: rtl/mips_id_ex_pipe.sv
// Purpose: ID->EX pipeline register with valid/ready handshake and a one-entry skid buffer.
// Latency: one cycle from acceptance to ex_* when the main entry is empty or popping.
// Backpressure: id_ready is a flop (= !skid_vld); EX stalls fill the skid entry, never a comb path to ID.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous kill of both held entries
//   id_valid/id_ready upstream handshake; id_rs, id_rt, id_imm, id_pc_incr, id_info payload
//   ex_valid/ex_ready downstream handshake; ex_rs, ex_rt, ex_imm, ex_pc_incr, ex_info payload
//   stall_cnt         saturating count of cycles with ex_valid & !ex_ready

`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif
`ifndef MIPS_ADDR_WIDTH
`define MIPS_ADDR_WIDTH 32
`endif
`ifndef MIPS_DECINFO_WIDTH
`define MIPS_DECINFO_WIDTH 16
`endif

module mips_id_ex_pipe #(
  parameter int DW = `MIPS_DATA_WIDTH,
  parameter int AW = `MIPS_ADDR_WIDTH,
  parameter int IW = `MIPS_DECINFO_WIDTH,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [DW-1:0] id_rs,
  input  logic [DW-1:0] id_rt,
  input  logic [DW-1:0] id_imm,
  input  logic [AW-1:0] id_pc_incr,
  input  logic [IW-1:0] id_info,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [DW-1:0] ex_rs,
  output logic [DW-1:0] ex_rt,
  output logic [DW-1:0] ex_imm,
  output logic [AW-1:0] ex_pc_incr,
  output logic [IW-1:0] ex_info,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [DW-1:0] imm;
    logic [AW-1:0] pc_incr;
    logic [IW-1:0] info;
  } pay_t;

  pay_t          in_dat;
  pay_t          main_dat;
  pay_t          skid_dat;
  logic          main_vld;
  logic          skid_vld;
  logic          acc;
  logic          pop;
  logic          adv;
  logic [CW-1:0] stall_q;

  assign in_dat = '{rs: id_rs, rt: id_rt, imm: id_imm, pc_incr: id_pc_incr, info: id_info};

  assign acc = id_valid & ~skid_vld;
  assign pop = main_vld & ex_ready;
  // Main slot can take a new occupant this edge.
  assign adv = ~main_vld | pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (flush) begin
      // Payload left as-is; ex_info gating hides stale contents.
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (adv) begin
      if (skid_vld) begin
        // Skid is older than anything at the input, so it goes first.
        main_dat <= skid_dat;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (acc) begin
        main_dat <= in_dat;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (acc) begin
      skid_dat <= in_dat;
      skid_vld <= 1'b1;
    end
  end

  // Stall counter ignores flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_vld && !ex_ready && (stall_q != {CW{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign id_ready   = ~skid_vld;
  assign ex_valid   = main_vld;
  assign ex_rs      = main_dat.rs;
  assign ex_rt      = main_dat.rt;
  assign ex_imm     = main_dat.imm;
  assign ex_pc_incr = main_dat.pc_incr;
  assign ex_info    = main_vld ? main_dat.info : '0;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_mips_id_ex_pipe.sv
module tb_mips_id_ex_pipe;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 16;
  localparam int CW = 4;
  localparam int SMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [DW-1:0] imm;
    logic [AW-1:0] pc;
    logic [IW-1:0] info;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          id_valid = 1'b0;
  logic          id_ready;
  logic [DW-1:0] id_rs = '0;
  logic [DW-1:0] id_rt = '0;
  logic [DW-1:0] id_imm = '0;
  logic [AW-1:0] id_pc_incr = '0;
  logic [IW-1:0] id_info = '0;
  logic          ex_valid;
  logic          ex_ready = 1'b0;
  logic [DW-1:0] ex_rs;
  logic [DW-1:0] ex_rt;
  logic [DW-1:0] ex_imm;
  logic [AW-1:0] ex_pc_incr;
  logic [IW-1:0] ex_info;
  logic [CW-1:0] stall_cnt;

  mips_id_ex_pipe #(.DW(DW), .AW(AW), .IW(IW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm), .id_pc_incr(id_pc_incr), .id_info(id_info),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_imm(ex_imm), .ex_pc_incr(ex_pc_incr), .ex_info(ex_info),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: in-order queue of held instructions (max 2) plus a stall count.
  beat_t q[$];
  int    scnt = 0;
  int    errs = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [DW-1:0] rs);
    beat_t b;
    b.rs   = rs;
    b.rt   = $urandom;
    b.imm  = $urandom;
    b.pc   = $urandom;
    b.info = IW'($urandom);
    return b;
  endfunction

  task automatic check_outputs(input string ctx);
    chk({ctx, ".ex_valid"}, 64'(ex_valid), 64'(q.size() > 0));
    chk({ctx, ".id_ready"}, 64'(id_ready), 64'(q.size() < 2));
    chk({ctx, ".stall_cnt"}, 64'(stall_cnt), 64'(scnt));
    if (q.size() > 0) begin
      chk({ctx, ".ex_rs"}, 64'(ex_rs), 64'(q[0].rs));
      chk({ctx, ".ex_rt"}, 64'(ex_rt), 64'(q[0].rt));
      chk({ctx, ".ex_imm"}, 64'(ex_imm), 64'(q[0].imm));
      chk({ctx, ".ex_pc_incr"}, 64'(ex_pc_incr), 64'(q[0].pc));
      chk({ctx, ".ex_info"}, 64'(ex_info), 64'(q[0].info));
    end else begin
      chk({ctx, ".ex_info_idle"}, 64'(ex_info), 64'd0);
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare 1 ns later.
  task automatic cycle(input string ctx, input bit v, input beat_t b, input bit er, input bit fl,
                       output bit accepted);
    bit acc;
    bit pop;
    id_valid   = v;
    id_rs      = b.rs;
    id_rt      = b.rt;
    id_imm     = b.imm;
    id_pc_incr = b.pc;
    id_info    = b.info;
    ex_ready   = er;
    flush      = fl;
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && er;
    @(posedge clk);
    if (q.size() > 0 && !er && scnt < SMAX) scnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    #1;
    check_outputs(ctx);
    accepted = acc;
  endtask

  // Asynchronous reset asserted between edges; checked before any edge arrives.
  task automatic async_reset(input string ctx);
    id_valid = 1'b0;
    flush    = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk({ctx, ".rst_ex_valid"}, 64'(ex_valid), 64'd0);
    chk({ctx, ".rst_id_ready"}, 64'(id_ready), 64'd1);
    chk({ctx, ".rst_stall_cnt"}, 64'(stall_cnt), 64'd0);
    chk({ctx, ".rst_ex_rs"}, 64'(ex_rs), 64'd0);
    chk({ctx, ".rst_ex_info"}, 64'(ex_info), 64'd0);
    q.delete();
    scnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    beat_t a, b, c, x, y, hold;
    bit    ac;
    bit    pend;

    // Reset state, observed while rst is still asserted.
    #12;
    chk("reset.ex_valid", 64'(ex_valid), 64'd0);
    chk("reset.id_ready", 64'(id_ready), 64'd1);
    chk("reset.stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset.ex_info", 64'(ex_info), 64'd0);
    chk("reset.ex_pc_incr", 64'(ex_pc_incr), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming: four beats back-to-back, EX always ready.
    for (int i = 1; i <= 4; i++) cycle("stream", 1'b1, mk(DW'(i)), 1'b1, 1'b0, ac);
    cycle("stream_drain", 1'b0, mk('0), 1'b1, 1'b0, ac);
    chk("stream.stall_zero", 64'(stall_cnt), 64'd0);

    // Back-pressure: A to main, B to skid, C held by ID until space appears.
    a = mk(32'hA); b = mk(32'hB); c = mk(32'hC);
    cycle("bp_a", 1'b1, a, 1'b0, 1'b0, ac);
    cycle("bp_b", 1'b1, b, 1'b0, 1'b0, ac);
    cycle("bp_c_hold", 1'b1, c, 1'b0, 1'b0, ac);
    chk("bp.c_not_taken", 64'(ac), 64'd0);
    cycle("bp_c_hold2", 1'b1, c, 1'b0, 1'b0, ac);
    cycle("bp_pop_a", 1'b1, c, 1'b1, 1'b0, ac);
    chk("bp.b_in_main", 64'(ex_rs), 64'hB);
    cycle("bp_pop_b", 1'b1, c, 1'b1, 1'b0, ac);
    chk("bp.c_in_main", 64'(ex_rs), 64'hC);
    cycle("bp_pop_c", 1'b0, c, 1'b1, 1'b0, ac);

    // Flush with both entries full and a beat offered.
    cycle("fl_a", 1'b1, mk(32'h11), 1'b0, 1'b0, ac);
    cycle("fl_b", 1'b1, mk(32'h12), 1'b0, 1'b0, ac);
    cycle("fl_go", 1'b1, mk(32'h13), 1'b0, 1'b1, ac);
    chk("flush.ex_valid", 64'(ex_valid), 64'd0);
    chk("flush.ex_info", 64'(ex_info), 64'd0);
    chk("flush.id_ready", 64'(id_ready), 64'd1);
    cycle("fl_after", 1'b0, mk('0), 1'b1, 1'b0, ac);

    // Async reset mid-stream with the skid entry full.
    cycle("ar_a", 1'b1, mk(32'h21), 1'b0, 1'b0, ac);
    cycle("ar_b", 1'b1, mk(32'h22), 1'b0, 1'b0, ac);
    async_reset("ar");

    // Saturation: one held instruction, EX stalled for 20 cycles.
    cycle("sat_fill", 1'b1, mk(32'h31), 1'b0, 1'b0, ac);
    for (int i = 0; i < 20; i++) cycle("sat", 1'b0, mk('0), 1'b0, 1'b0, ac);
    chk("sat.stall_cnt", 64'(stall_cnt), 64'(SMAX));
    cycle("sat_flush", 1'b0, mk('0), 1'b0, 1'b1, ac);
    chk("sat.kept_on_flush", 64'(stall_cnt), 64'(SMAX));
    async_reset("sat_rst");

    // Simultaneous pop and accept with skid empty.
    x = mk(32'h41); y = mk(32'h42);
    cycle("pa_x", 1'b1, x, 1'b1, 1'b0, ac);
    cycle("pa_y", 1'b1, y, 1'b1, 1'b0, ac);
    chk("pa.y_on_ex", 64'(ex_rs), 64'h42);
    chk("pa.skid_empty", 64'(id_ready), 64'd1);
    cycle("pa_drain", 1'b0, y, 1'b1, 1'b0, ac);

    // Random traffic; ID holds an unaccepted beat stable.
    pend = 1'b0;
    hold = mk('0);
    for (int i = 0; i < 3000; i++) begin
      if (!pend) begin
        hold = mk($urandom);
        pend = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rnd_rst");
        pend = 1'b0;
      end else begin
        cycle("rnd", pend, hold, ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0), ac);
        if (ac) pend = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/mips_id_ex_pipe.md
Name: mips_id_ex_pipe

Overview:
- Decode-to-execute pipeline register with a valid/ready handshake and a one-entry skid buffer.
- Sits directly upstream of the regular EX ALU. Captures rs/rt operands, immediate, incremented PC and decode-info vector from ID, and presents them to EX.
- Fully registered upstream ready: EX back-pressure never creates a combinational path back into ID.
- Supports pipeline flush and keeps a saturating stall counter for debug.

Parameters:
DW, `MIPS_DATA_WIDTH (32), operand/immediate width
AW, `MIPS_ADDR_WIDTH (32), PC width
IW, `MIPS_DECINFO_WIDTH, decode-info vector width
CW, 16, stall counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all held instructions
id_valid  input  1  ID presents an instruction
id_ready  output  1  pipe can accept; registered, equals !skid_vld
id_rs  input  DW  rs operand
id_rt  input  DW  rt operand
id_imm  input  DW  extended immediate
id_pc_incr  input  AW  PC+4
id_info  input  IW  decode info
ex_valid  output  1  main entry holds an instruction
ex_ready  input  1  EX consumes main entry this cycle
ex_rs  output  DW  registered rs
ex_rt  output  DW  registered rt
ex_imm  output  DW  registered imm
ex_pc_incr  output  AW  registered PC+4
ex_info  output  IW  registered info, forced to 0 when !ex_valid
stall_cnt  output  CW  saturating count of cycles with ex_valid & !ex_ready

Behaviour:
- Reset (rst=1, asynchronous): main_vld=0, skid_vld=0, all payload registers 0, stall_cnt=0. Outputs: ex_valid=0, id_ready=1, ex_* = 0. Deassertion takes effect at the next edge; no partial state survives reset asserted mid-transfer.
- Handshake events: acc = id_valid & id_ready; pop = ex_valid & ex_ready. Payload is stable while ex_valid & !ex_ready.
- Latency: an accepted instruction appears on ex_* the cycle after acceptance when main is empty or popping.
- Update rules per edge, flush=0:
  - Main empty or pop, skid_vld=1: main <- skid, skid_vld <- 0. id_ready was 0, so acc=0.
  - Main empty or pop, skid_vld=0, acc: main <- input, main_vld <- 1.
  - Main empty or pop, skid_vld=0, !acc: main_vld <- 0.
  - Main full, !pop, acc: skid <- input, skid_vld <- 1. id_ready drops next cycle.
  - Main full, !pop, !acc: hold.
- Ordering: strict FIFO; the skid entry is never bypassed.
- Capacity: two entries. id_ready=0 exactly while skid_vld=1. id_valid with id_ready=0 is a no-op; ID must hold.
- Flush (highest priority after reset): main_vld <- 0 and skid_vld <- 0 at the edge. A beat accepted in the same cycle is discarded, as is a simultaneous pop: EX still sees that beat this cycle and is responsible for squashing it. Payload registers are not cleared; ex_info gating hides them.
- ex_info gating: ex_info = main_vld ? info_reg : 0. No spurious ALU op requests when idle.
- stall_cnt increments each cycle ex_valid & !ex_ready, saturates at 2^CW-1, is unaffected by flush, and clears only on rst.
- No combinational path from ex_ready or id_valid to id_ready.

Test Plan:
- Streaming: id_valid=1 for 4 beats (rs=1..4), ex_ready=1 constantly -> ex_rs 1,2,3,4 on consecutive cycles starting one cycle after the first accept; id_ready stays 1; stall_cnt=0.
- Back-pressure: 3 beats A,B,C offered, ex_ready=0 -> A in main, B in skid, id_ready=0 from the cycle after B; C held by ID. Raise ex_ready -> outputs A,B,C in order; id_ready returns to 1 one cycle after B moves to main. stall_cnt counts the stalled cycles exactly.
- Flush with both entries full plus id_valid=1 -> next cycle ex_valid=0, ex_info=0, id_ready=1. The flushed input beat never appears on ex_*.
- Asynchronous reset mid-stream: assert rst between clock edges with skid full -> ex_valid=0, id_ready=1, stall_cnt=0 immediately, without waiting for an edge.
- Saturation: CW=4, hold ex_ready=0 for 20 cycles -> stall_cnt sticks at 15.
- Simultaneous pop and accept with skid empty: main=X popped, new Y accepted the same cycle -> Y on ex_* next cycle; skid_vld stays 0.
